run_scan_ctrl: RTL and testbench



---
 rtl/run_scan_pkg.sv | 12 +
 rtl/run_len_det.sv | 57 +++++
 rtl/run_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_run_scan_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/run_scan_pkg.sv
// Shared types and constants for the frame run-scan controller and its detector.
package run_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } scan_state_t;

  localparam int unsigned MIN_RUN_LEN = 2;

endpackage

// File: rtl/run_len_det.sv
// Consecutive-bit run detector: counts equal bits (either polarity) up to a
// threshold and flags every bit at which the run length reaches it.
module run_len_det #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  input  logic [CNT_W-1:0] thr,
  output logic             det
);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_new_s;
  logic             last_q, last_d;

  // cnt==0 only right after a clear, so it doubles as the first-bit marker
  always_comb begin
    cnt_new_s = CNT_W'(1);
    if (cnt_q == '0 || bit_in != last_q) begin
      cnt_new_s = CNT_W'(1);
    end else if (cnt_q >= thr) begin
      cnt_new_s = thr;
    end else begin
      cnt_new_s = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    det    = 1'b0;
    if (clr) begin
      cnt_d  = '0;
      last_d = 1'b0;
    end else if (en) begin
      cnt_d  = cnt_new_s;
      last_d = bit_in;
      det    = (cnt_new_s >= thr);
    end else begin
      cnt_d  = cnt_q;
      last_d = last_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/run_scan_ctrl.sv
// Frame-level scan controller: latches a frame and threshold on start, feeds the
// frame LSB-first through run_len_det and collects hit / count / first index.
module run_scan_ctrl
  import run_scan_pkg::*;
#(
  parameter  int FRAME_W = 16,
  parameter  int CNT_W   = 4,
  localparam int IDX_W   = $clog2(FRAME_W),
  localparam int HC_W    = $clog2(FRAME_W + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic [CNT_W-1:0]   run_len,
  output logic               busy,
  output logic               done,
  output logic               hit,
  output logic [HC_W-1:0]    hit_count,
  output logic [IDX_W-1:0]   first_idx
);

  scan_state_t        state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]   thr_q, thr_d, thr_clamp_s;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               hit_q, hit_d;
  logic [HC_W-1:0]    hit_count_q, hit_count_d;
  logic [IDX_W-1:0]   first_idx_q, first_idx_d;
  logic               accept_s, scan_s, last_bit_s, det_s;

  assign accept_s    = (state_q == S_IDLE) && start;
  assign scan_s      = (state_q == S_SCAN);
  assign last_bit_s  = (idx_q == IDX_W'(FRAME_W - 1));
  assign thr_clamp_s = (run_len < CNT_W'(MIN_RUN_LEN)) ? CNT_W'(MIN_RUN_LEN) : run_len;

  run_len_det #(.CNT_W(CNT_W)) u_det (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept_s),
    .en     (scan_s),
    .bit_in (frame_q[idx_q]),
    .thr    (thr_q),
    .det    (det_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_SCAN : S_IDLE;
      S_SCAN:  state_d = last_bit_s ? S_DONE : S_SCAN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_IDLE:  begin busy = 1'b0; done = 1'b0; end
      S_SCAN:  begin busy = 1'b1; done = 1'b0; end
      S_DONE:  begin busy = 1'b1; done = 1'b1; end
      default: begin busy = 1'b0; done = 1'b0; end
    endcase
  end

  // Results are cleared only on acceptance, so they hold through IDLE
  always_comb begin
    frame_d     = frame_q;
    thr_d       = thr_q;
    idx_d       = idx_q;
    hit_d       = hit_q;
    hit_count_d = hit_count_q;
    first_idx_d = first_idx_q;
    if (accept_s) begin
      frame_d     = frame_in;
      thr_d       = thr_clamp_s;
      idx_d       = '0;
      hit_d       = 1'b0;
      hit_count_d = '0;
      first_idx_d = '0;
    end else if (scan_s) begin
      if (det_s) begin
        hit_count_d = hit_count_q + HC_W'(1);
        if (!hit_q) begin
          hit_d       = 1'b1;
          first_idx_d = idx_q;
        end else begin
          hit_d       = hit_q;
          first_idx_d = first_idx_q;
        end
      end else begin
        hit_count_d = hit_count_q;
      end
      if (last_bit_s) begin
        idx_d = idx_q;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_q     <= '0;
      thr_q       <= '0;
      idx_q       <= '0;
      hit_q       <= 1'b0;
      hit_count_q <= '0;
      first_idx_q <= '0;
    end else begin
      frame_q     <= frame_d;
      thr_q       <= thr_d;
      idx_q       <= idx_d;
      hit_q       <= hit_d;
      hit_count_q <= hit_count_d;
      first_idx_q <= first_idx_d;
    end
  end

  assign hit       = hit_q;
  assign hit_count = hit_count_q;
  assign first_idx = first_idx_q;

endmodule

// File: tb/tb_run_scan_ctrl.sv
// Directed, table-driven bench for run_scan_ctrl with hand-computed results
// plus sequences for held start and mid-scan reset.
module tb_run_scan_ctrl;

  localparam int FRAME_W = 16;
  localparam int CNT_W   = 4;

  logic                       clk = 1'b0;
  logic                       reset = 1'b0;
  logic                       start = 1'b0;
  logic [FRAME_W-1:0]         frame_in = '0;
  logic [CNT_W-1:0]           run_len = '0;
  logic                       busy, done, hit;
  logic [$clog2(FRAME_W+1)-1:0] hit_count;
  logic [$clog2(FRAME_W)-1:0]   first_idx;

  int errors = 0;
  int checks = 0;

  run_scan_ctrl #(.FRAME_W(FRAME_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .frame_in  (frame_in),
    .run_len   (run_len),
    .busy      (busy),
    .done      (done),
    .hit       (hit),
    .hit_count (hit_count),
    .first_idx (first_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] frame;
    logic [3:0]  rl;
    int          exp_hit;
    int          exp_cnt;
    int          exp_first;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Watch the handshake after an accepted start until busy drops (bounded).
  task automatic watch(output int busy_n, output int done_n, output int done_at);
    busy_n = 0; done_n = 0; done_at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = busy_n;
      end
      if (!busy) break;
    end
  endtask

  task automatic issue_start(input logic [15:0] f, input logic [3:0] rl, input bit hold);
    @(negedge clk);
    frame_in = f;
    run_len  = rl;
    start    = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  initial begin
    int bn, dn, da;

    vecs[0] = '{16'h0000, 4'd4,  1, 13, 3};
    vecs[1] = '{16'h00F0, 4'd4,  1, 7,  3};
    vecs[2] = '{16'hAAAA, 4'd2,  0, 0,  0};
    vecs[3] = '{16'hFFFF, 4'd15, 1, 2,  14};
    vecs[4] = '{16'h0001, 4'd0,  1, 14, 2};
    vecs[5] = '{16'h0001, 4'd1,  1, 14, 2};

    #12;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_hit", int'(hit), 0);
    chk("reset_count", int'(hit_count), 0);
    chk("reset_first", int'(first_idx), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      issue_start(vecs[v].frame, vecs[v].rl, 1'b0);
      watch(bn, dn, da);
      chk($sformatf("v%0d_busy_cycles", v), bn, 17);
      chk($sformatf("v%0d_done_pulses", v), dn, 1);
      chk($sformatf("v%0d_done_pos", v), da, 17);
      chk($sformatf("v%0d_hit", v), int'(hit), vecs[v].exp_hit);
      chk($sformatf("v%0d_count", v), int'(hit_count), vecs[v].exp_cnt);
      chk($sformatf("v%0d_first", v), int'(first_idx), vecs[v].exp_first);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_hold_count", v), int'(hit_count), vecs[v].exp_cnt);
    end

    // Start held through the whole scan, frame changed mid-scan
    issue_start(16'h00F0, 4'd4, 1'b1);
    repeat (4) @(negedge clk);
    frame_in = 16'hFFFF;
    watch(bn, dn, da);
    chk("hold_busy_cycles", bn + 4, 17);
    chk("hold_done_pulses", dn, 1);
    chk("hold_count", int'(hit_count), 7);
    chk("hold_first", int'(first_idx), 3);
    @(negedge clk);
    start = 1'b0;
    chk("hold_restart_busy", int'(busy), 1);
    chk("hold_restart_cleared", int'(hit_count), 0);
    watch(bn, dn, da);
    chk("hold2_busy_cycles", bn + 1, 17);
    chk("hold2_done_pulses", dn, 1);
    chk("hold2_count", int'(hit_count), 13);
    chk("hold2_first", int'(first_idx), 3);

    // Reset asserted while idx=5 is being scanned
    issue_start(16'h0000, 4'd4, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    chk("pre_reset_count", int'(hit_count), 2);
    reset = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_hit", int'(hit), 0);
    chk("arst_count", int'(hit_count), 0);
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("arst_no_done", dn, 0);
    issue_start(16'h0000, 4'd4, 1'b0);
    watch(bn, dn, da);
    chk("post_rst_done_pulses", dn, 1);
    chk("post_rst_count", int'(hit_count), 13);
    chk("post_rst_first", int'(first_idx), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
